// File: rtl/cell_grid_ctrl.sv
// ----------------------------------------------------------------------------
// cell_grid_ctrl
//   Frame sequencer that sits after cell_histogram. The upstream line buffer
//   produces one 8-row window sum per pixel row. This block keeps only the
//   windows that line up with the cell grid (window row mod CELL_SIZE == 0) and
//   drops the others. Each kept histogram is tagged with its cell coordinates
//   and row/frame-last flags. One frame is processed per start pulse.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active-low
//   start          pulse; begins a frame when idle
//   h_valid        window histogram valid (from cell_histogram)
//   h_ready        window histogram ready (to cell_histogram)
//   h_histogram    window histogram
//   out_valid      registered output valid
//   out_ready      downstream ready
//   out_histogram  kept cell histogram
//   cell_x/cell_y  cell column / row of the current output
//   row_last       output is the last cell of its row
//   frame_last     output is the last cell of the frame
//   busy           a frame is in progress
//   done           one-cycle pulse at frame completion
// ----------------------------------------------------------------------------
module cell_grid_ctrl #(
    parameter  int IMAGE_WIDTH     = 640,
    parameter  int IMAGE_HEIGHT    = 480,
    parameter  int CELL_SIZE       = 8,
    parameter  int HISTOGRAM_WIDTH = 140,
    localparam int CX              = IMAGE_WIDTH / CELL_SIZE,
    localparam int CY              = IMAGE_HEIGHT / CELL_SIZE,
    localparam int XW              = (CX > 1) ? $clog2(CX) : 1,
    localparam int YW              = (CY > 1) ? $clog2(CY) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       h_valid,
    output logic                       h_ready,
    input  logic [HISTOGRAM_WIDTH-1:0] h_histogram,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [HISTOGRAM_WIDTH-1:0] out_histogram,
    output logic [XW-1:0]              cell_x,
    output logic [YW-1:0]              cell_y,
    output logic                       row_last,
    output logic                       frame_last,
    output logic                       busy,
    output logic                       done
);

    localparam int WR = IMAGE_HEIGHT - CELL_SIZE + 1;
    localparam int RW = (WR > 1) ? $clog2(WR) : 1;
    localparam int PW = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;

    localparam logic [XW-1:0] COL_LAST   = XW'(CX - 1);
    localparam logic [YW-1:0] CY_LAST    = YW'(CY - 1);
    localparam logic [RW-1:0] WROW_LAST  = RW'(WR - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CELL_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                     r_state;
    logic [XW-1:0]              r_col;
    logic [RW-1:0]              r_wrow;
    logic [PW-1:0]              r_phase;
    logic [YW-1:0]              r_cy;
    logic                       r_out_valid;
    logic [HISTOGRAM_WIDTH-1:0] r_out_hist;
    logic [XW-1:0]              r_cell_x;
    logic [YW-1:0]              r_cell_y;
    logic                       r_row_last;
    logic                       r_frame_last;

    logic w_keep;
    logic w_h_ready;
    logic w_accept;
    logic w_col_last;
    logic w_wrow_last;

    assign w_keep      = (r_phase == '0);
    assign w_col_last  = (r_col == COL_LAST);
    assign w_wrow_last = (r_wrow == WROW_LAST);
    // Dropped windows are consumed regardless of output back-pressure.
    assign w_h_ready   = (r_state == S_RUN) && (!w_keep || !r_out_valid || out_ready);
    assign w_accept    = h_valid && w_h_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_wrow       <= '0;
            r_phase      <= '0;
            r_cy         <= '0;
            r_out_valid  <= 1'b0;
            r_out_hist   <= '0;
            r_cell_x     <= '0;
            r_cell_y     <= '0;
            r_row_last   <= 1'b0;
            r_frame_last <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_col   <= '0;
                        r_wrow  <= '0;
                        r_phase <= '0;
                        r_cy    <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept && w_col_last && w_wrow_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!r_out_valid) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Position counters; cell row advances when the phase wraps.
            if (w_accept) begin
                if (w_col_last) begin
                    r_col  <= '0;
                    r_wrow <= w_wrow_last ? '0 : r_wrow + 1'b1;
                    if (r_phase == PHASE_LAST) begin
                        r_phase <= '0;
                        r_cy    <= r_cy + 1'b1;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            // Output register: a new kept word may load in the same cycle
            // the previous one drains.
            if (w_accept && w_keep) begin
                r_out_valid  <= 1'b1;
                r_out_hist   <= h_histogram;
                r_cell_x     <= r_col;
                r_cell_y     <= r_cy;
                r_row_last   <= w_col_last;
                r_frame_last <= w_col_last && (r_cy == CY_LAST);
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign h_ready       = w_h_ready;
    assign out_valid     = r_out_valid;
    assign out_histogram = r_out_hist;
    assign cell_x        = r_cell_x;
    assign cell_y        = r_cell_y;
    assign row_last      = r_row_last;
    assign frame_last    = r_frame_last;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_cell_grid_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cell_grid_ctrl
//   Directed bench for cell_grid_ctrl with a 32x24 image (4x3 cells, 17 window
//   rows of 4 inputs each). Inputs are driven on the falling edge and outputs
//   sampled 1 time unit later. Expected cell order, coordinates and data are
//   derived from the input index: output k is cell (k%4, k/4) and comes from
//   input 32*(k/4) + k%4.
// ----------------------------------------------------------------------------
module tb_cell_grid_ctrl;

    localparam int HW    = 140;
    localparam int N_IN  = 68;
    localparam int N_OUT = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          h_valid;
    logic          h_ready;
    logic [HW-1:0] h_histogram;
    logic          out_valid;
    logic          out_ready;
    logic [HW-1:0] out_histogram;
    logic [1:0]    cell_x;
    logic [1:0]    cell_y;
    logic          row_last;
    logic          frame_last;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    cell_grid_ctrl #(
        .IMAGE_WIDTH    (32),
        .IMAGE_HEIGHT   (24),
        .CELL_SIZE      (8),
        .HISTOGRAM_WIDTH(HW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .h_valid      (h_valid),
        .h_ready      (h_ready),
        .h_histogram  (h_histogram),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_histogram(out_histogram),
        .cell_x       (cell_x),
        .cell_y       (cell_y),
        .row_last     (row_last),
        .frame_last   (frame_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HW-1:0] mkdata(input int idx);
        logic [HW-1:0] d;
        d           = '0;
        d[15:0]     = 16'(idx);
        d[79:64]    = 16'(idx * 3 + 7);
        d[139:124]  = ~16'(idx);
        return d;
    endfunction

    // mode 0: out_ready=1; mode 1: out_ready toggles; mode 2: ready until the
    // last wrow-0 cell is loaded, then stalled until wrow 7 is consumed.
    task automatic run_frame(input int mode, input int mid_start_cyc, input int abort_at);
        int in_idx = 0;
        int out_cnt = 0;
        int cyc = 0;
        int fl_cyc = -1;
        int ex, ey;
        bit m_valid = 1'b0;
        bit fin = 1'b0;
        bit keep, er, ai, ao, ed;

        @(negedge clk);
        start     = 1'b1;
        h_valid   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;

        while (!fin && cyc < 1000) begin
            if (in_idx == abort_at) return;
            h_valid     = (in_idx < N_IN);
            h_histogram = mkdata(in_idx);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = (out_cnt < 3) || (in_idx >= 32);
            endcase
            start = (cyc == mid_start_cyc);
            #1;
            keep = ((in_idx / 4) % 8) == 0;
            er   = (in_idx < N_IN) && (!keep || !m_valid || out_ready);
            check("h_ready", 160'(h_ready), 160'(er));
            check("out_valid", 160'(out_valid), 160'(m_valid));
            if (m_valid) begin
                ex = out_cnt % 4;
                ey = out_cnt / 4;
                check("cell_x", 160'(cell_x), 160'(ex));
                check("cell_y", 160'(cell_y), 160'(ey));
                check("row_last", 160'(row_last), 160'(ex == 3));
                check("frame_last", 160'(frame_last), 160'(out_cnt == N_OUT - 1));
                check("out_histogram", 160'(out_histogram), 160'(mkdata(32 * ey + ex)));
            end
            ed = (fl_cyc >= 0) && (cyc == fl_cyc + 2);
            check("done", 160'(done), 160'(ed));
            check("busy", 160'(busy), 160'(1'b1));
            ai = h_valid && er;
            ao = m_valid && out_ready;
            if (ao) begin
                if (out_cnt == N_OUT - 1) fl_cyc = cyc;
                out_cnt++;
            end
            if (ai && keep) m_valid = 1'b1;
            else if (ao)    m_valid = 1'b0;
            if (ai) in_idx++;
            if (ed) fin = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check("frame_finished", 160'(fin), 160'(1'b1));
        check("out_count", 160'(out_cnt), 160'(N_OUT));
        #1;
        check("busy_after", 160'(busy), 160'(1'b0));
        check("done_after", 160'(done), 160'(1'b0));
        check("out_valid_after", 160'(out_valid), 160'(1'b0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 160'(out_valid), 160'(1'b0));
        check({tag, "_h_ready"}, 160'(h_ready), 160'(1'b0));
        check({tag, "_busy"}, 160'(busy), 160'(1'b0));
        check({tag, "_done"}, 160'(done), 160'(1'b0));
        check({tag, "_hist"}, 160'(out_histogram), 160'(0));
        check({tag, "_cx"}, 160'(cell_x), 160'(0));
        check({tag, "_cy"}, 160'(cell_y), 160'(0));
        check({tag, "_rl"}, 160'(row_last), 160'(1'b0));
        check({tag, "_fl"}, 160'(frame_last), 160'(1'b0));
    endtask

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        h_valid     = 1'b0;
        out_ready   = 1'b0;
        h_histogram = '0;

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start       = 1'($urandom);
            h_valid     = 1'($urandom);
            out_ready   = 1'($urandom);
            h_histogram = {$urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
            check_reset_outputs("reset");
        end
        @(negedge clk);
        start   = 1'b0;
        h_valid = 1'b0;
        rst     = 1'b1;

        // Full-throughput frame.
        run_frame(0, -1, -1);

        // Toggling downstream ready.
        run_frame(1, -1, -1);

        // Long stall while dropped rows 1..7 are consumed.
        run_frame(2, -1, -1);

        // h_valid while idle is never accepted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            h_valid     = 1'b1;
            h_histogram = mkdata(99);
            #1;
            check("idle_h_ready", 160'(h_ready), 160'(1'b0));
            check("idle_busy", 160'(busy), 160'(1'b0));
        end

        // start pulsed mid-frame is ignored.
        run_frame(0, 20, -1);

        // Reset in the middle of a frame, then a clean frame.
        run_frame(0, -1, 30);
        h_valid = 1'b0;
        rst     = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        run_frame(0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
